// File: rtl/bb_and_pkg.sv
// ============================================================================
//  Module   : bb_and_pkg
//  Purpose  : Shared types and constants for the black-box AND checker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bb_and_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int VEC_PER_ITER = 4;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bb_and_expdelay.sv
// ============================================================================
//  Module   : bb_and_expdelay
//  Purpose  : LATENCY-deep {valid, expected} delay line; LATENCY=0 is a wire.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bb_and_expdelay
    import bb_and_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_valid,
    input  logic i_exp,
    output logic o_valid,
    output logic o_exp
);

    generate
        if (LATENCY == 0) begin : g_bypass
            assign o_valid = i_valid;
            assign o_exp   = i_exp;

            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_clr};
        end else begin : g_shift
            logic [LATENCY-1:0] r_valid;
            logic [LATENCY-1:0] r_exp;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= '0;
                    r_exp   <= '0;
                end else if (i_clr) begin
                    r_valid <= '0;
                    r_exp   <= '0;
                end else begin
                    r_valid[0] <= i_valid;
                    r_exp[0]   <= i_exp;
                    for (int k = 1; k < LATENCY; k++) begin
                        r_valid[k] <= r_valid[k-1];
                        r_exp[k]   <= r_exp[k-1];
                    end
                end
            end

            assign o_valid = r_valid[LATENCY-1];
            assign o_exp   = r_exp[LATENCY-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bb_and_checker.sv
// ============================================================================
//  Module   : bb_and_checker
//  Purpose  : Drives exhaustive a/b sweeps into the AND wrapper and counts
//             result mismatches a fixed latency later.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bb_and_checker
    import bb_and_pkg::*;
#(
    parameter int ITERS   = 1,
    parameter int LATENCY = 1,
    parameter int ERR_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    output logic             io_a,
    output logic             io_b,
    input  logic             io_result,
    output logic             io_busy,
    output logic             io_done,
    output logic             io_pass,
    output logic [ERR_W-1:0] io_errCount
);

    localparam int               c_num_vec    = VEC_PER_ITER * ITERS;
    localparam int               c_cnt_w      = clog2(c_num_vec);
    localparam logic [c_cnt_w-1:0] c_last_vec = c_cnt_w'(c_num_vec - 1);
    localparam logic [3:0]       c_drain_last = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [ERR_W-1:0] c_err_max    = '1;

    state_t               r_state;
    state_t               w_next;
    logic                 w_start;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_drain;
    logic [ERR_W-1:0]     r_err;
    logic                 w_in_run;
    logic                 w_dly_valid;
    logic                 w_dly_exp;
    logic                 w_mismatch;

    assign w_in_run = (r_state == ST_RUN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (io_start) begin
                    w_next  = ST_RUN;
                    w_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_last_vec) begin
                    w_next = (LATENCY > 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (r_drain == c_drain_last) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // r_drain counts DRAIN cycles so every in-flight vector reaches the compare.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_in_run) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (r_state == ST_DRAIN) begin
                r_drain <= r_drain + 4'd1;
            end else begin
                r_drain <= '0;
            end
        end
    end

    assign io_a = w_in_run & r_cnt[0];
    assign io_b = w_in_run & r_cnt[1];

    bb_and_expdelay #(
        .LATENCY (LATENCY)
    ) u_expdelay (
        .clk     (clock),
        .rst_n   (reset),
        .i_clr   (w_start),
        .i_valid (w_in_run),
        .i_exp   (io_a & io_b),
        .o_valid (w_dly_valid),
        .o_exp   (w_dly_exp)
    );

    assign w_mismatch = w_dly_valid & (io_result != w_dly_exp);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= '0;
        end else if (w_start) begin
            r_err <= '0;
        end else if (w_mismatch && (r_err != c_err_max)) begin
            r_err <= r_err + ERR_W'(1);
        end
    end

    assign io_busy     = w_in_run | (r_state == ST_DRAIN);
    assign io_done     = (r_state == ST_DONE);
    assign io_pass     = io_done & (r_err == '0);
    assign io_errCount = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bb_and_checker.sv
// ============================================================================
//  Module   : tb_bb_and_checker
//  Purpose  : Four checker configurations driven against scripted responders.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bb_and_checker;

    localparam int M_IDEAL = 0;
    localparam int M_ST0   = 1;
    localparam int M_ST1   = 2;
    localparam int M_RAND  = 3;

    logic       clk = 1'b0;
    logic [3:0] rst_n;
    logic [3:0] start_i;
    logic [3:0] res;
    logic [3:0] a_o, b_o, busy_o, done_o, pass_o;
    logic [7:0] err0, err2, err3;
    logic [1:0] err1;
    logic [3:0] rnd;
    logic [7:0] hist [4];
    int         mode_r [4];

    int n_checks = 0;
    int n_pass   = 0;
    int cur_idx  = 0;
    int cur_t    = 0;

    always #5 clk = ~clk;

    bb_and_checker #(.ITERS(1), .LATENCY(1), .ERR_W(8)) u_dut0 (
        .clock(clk), .reset(rst_n[0]), .io_start(start_i[0]), .io_a(a_o[0]), .io_b(b_o[0]),
        .io_result(res[0]), .io_busy(busy_o[0]), .io_done(done_o[0]), .io_pass(pass_o[0]),
        .io_errCount(err0));
    bb_and_checker #(.ITERS(2), .LATENCY(1), .ERR_W(2)) u_dut1 (
        .clock(clk), .reset(rst_n[1]), .io_start(start_i[1]), .io_a(a_o[1]), .io_b(b_o[1]),
        .io_result(res[1]), .io_busy(busy_o[1]), .io_done(done_o[1]), .io_pass(pass_o[1]),
        .io_errCount(err1));
    bb_and_checker #(.ITERS(1), .LATENCY(0), .ERR_W(8)) u_dut2 (
        .clock(clk), .reset(rst_n[2]), .io_start(start_i[2]), .io_a(a_o[2]), .io_b(b_o[2]),
        .io_result(res[2]), .io_busy(busy_o[2]), .io_done(done_o[2]), .io_pass(pass_o[2]),
        .io_errCount(err2));
    bb_and_checker #(.ITERS(1), .LATENCY(3), .ERR_W(8)) u_dut3 (
        .clock(clk), .reset(rst_n[3]), .io_start(start_i[3]), .io_a(a_o[3]), .io_b(b_o[3]),
        .io_result(res[3]), .io_busy(busy_o[3]), .io_done(done_o[3]), .io_pass(pass_o[3]),
        .io_errCount(err3));

    function automatic int iters_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic int lat_of(input int i);
        case (i)
            2:       return 0;
            3:       return 3;
            default: return 1;
        endcase
    endfunction
    function automatic int errw_of(input int i);
        return (i == 1) ? 2 : 8;
    endfunction
    function automatic int get_err(input int i);
        case (i)
            0:       return int'(err0);
            1:       return int'(err1);
            2:       return int'(err2);
            default: return int'(err3);
        endcase
    endfunction

    // Wrapper stand-ins: ideal AND delayed by the instance latency, stuck, or noise.
    always @(posedge clk) begin
        rnd <= 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            hist[i] <= {hist[i][6:0], a_o[i] & b_o[i]};
        end
    end

    always_comb begin
        logic [8:0] tap;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            tap = {hist[i], a_o[i] & b_o[i]};
            case (mode_r[i])
                M_IDEAL: res[i] = tap[lat_of(i)];
                M_ST0:   res[i] = 1'b0;
                M_ST1:   res[i] = 1'b1;
                default: res[i] = rnd[i];
            endcase
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s inst=%0d t=%0d got=%0d want=%0d", name, cur_idx, cur_t, got, want);
        end
    endtask

    task automatic check_zero(input int idx);
        check("rst_a",    int'(a_o[idx]),    0);
        check("rst_b",    int'(b_o[idx]),    0);
        check("rst_busy", int'(busy_o[idx]), 0);
        check("rst_done", int'(done_o[idx]), 0);
        check("rst_pass", int'(pass_o[idx]), 0);
        check("rst_err",  get_err(idx),      0);
    endtask

    // Reference: cycle t after the start edge; vector i is live in cycle i+1 and
    // its result is judged in cycle i+1+L, the count appearing one cycle later.
    task automatic run(input int idx, input int mode, input int pulse_at,
                       input int abort_at, output int got_err, output int got_pass);
        int n, l, maxe, mism, exp_err, k, vi;
        bit golden, done_exp;
        n    = 4 * iters_of(idx);
        l    = lat_of(idx);
        maxe = (1 << errw_of(idx)) - 1;
        mism = 0;
        cur_idx     = idx;
        mode_r[idx] = mode;
        @(negedge clk) start_i[idx] = 1'b1;
        @(negedge clk) start_i[idx] = 1'b0;
        for (int t = 1; t <= n + l + 1; t++) begin
            cur_t = t;
            start_i[idx] = (t == pulse_at);
            if (t == abort_at) begin
                rst_n[idx]   = 1'b0;
                start_i[idx] = 1'b0;
                #1;
                check_zero(idx);
                @(negedge clk);
                @(negedge clk) rst_n[idx] = 1'b1;
                @(negedge clk);
                check_zero(idx);
                got_err  = get_err(idx);
                got_pass = int'(pass_o[idx]);
                return;
            end
            exp_err  = (mism > maxe) ? maxe : mism;
            k        = (t - 1) % 4;
            done_exp = (t == n + l + 1);
            check("a",    int'(a_o[idx]),    (t <= n) ? (k & 1) : 0);
            check("b",    int'(b_o[idx]),    (t <= n) ? (k >> 1) : 0);
            check("busy", int'(busy_o[idx]), (t <= n + l) ? 1 : 0);
            check("done", int'(done_o[idx]), done_exp ? 1 : 0);
            check("err",  get_err(idx),      exp_err);
            check("pass", int'(pass_o[idx]), (done_exp && exp_err == 0) ? 1 : 0);
            if (t > l && t <= n + l) begin
                vi     = t - 1 - l;
                golden = ((vi % 4) == 3);
                if (res[idx] != golden) mism++;
            end
            if (t < n + l + 1) @(negedge clk);
        end
        start_i[idx] = 1'b0;
        got_err  = get_err(idx);
        got_pass = int'(pass_o[idx]);
    endtask

    typedef struct {
        int idx;
        int mode;
        int exp_err;
        int exp_pass;
    } vec_t;

    initial begin
        vec_t tbl [8];
        int   ge, gp, idx;

        tbl[0] = '{0, M_IDEAL, 0, 1};
        tbl[1] = '{0, M_ST0,   1, 0};
        tbl[2] = '{0, M_ST1,   3, 0};
        tbl[3] = '{1, M_ST1,   3, 0};
        tbl[4] = '{2, M_IDEAL, 0, 1};
        tbl[5] = '{3, M_IDEAL, 0, 1};
        tbl[6] = '{1, M_IDEAL, 0, 1};
        tbl[7] = '{2, M_ST1,   3, 0};

        for (int i = 0; i < 4; i++) begin
            mode_r[i] = M_IDEAL;
            hist[i]   = '0;
        end
        rst_n   = '0;
        start_i = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cur_idx = i;
            check_zero(i);
        end
        rst_n = '1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run(tbl[v].idx, tbl[v].mode, 0, 0, ge, gp);
            check("tbl_err",  ge, tbl[v].exp_err);
            check("tbl_pass", gp, tbl[v].exp_pass);
        end

        // Start pulsed mid-run must not restart or shift the done timing.
        run(0, M_IDEAL, 2, 0, ge, gp);
        check("pulse_pass", gp, 1);
        run(3, M_ST0, 4, 0, ge, gp);
        check("pulse_err", ge, 1);

        // Reset with a nonzero count in flight, then a clean run.
        run(0, M_ST1, 0, 0, ge, gp);
        run(0, M_ST1, 0, 4, ge, gp);
        run(0, M_IDEAL, 0, 0, ge, gp);
        check("post_rst_pass", gp, 1);
        run(3, M_ST1, 0, 2, ge, gp);
        run(3, M_IDEAL, 0, 0, ge, gp);
        check("post_rst_pass3", gp, 1);

        for (int r = 0; r < 12; r++) begin
            idx = $urandom_range(0, 3);
            run(idx, M_RAND, $urandom_range(0, 3), 0, ge, gp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
